// File: rtl/proc_pkg.sv
// Shared types and constants for the processor sequencing logic: opcodes,
// FSM states, ALU selects and instruction field positions.
package proc_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_e;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_FETCH,
        ST_LOAD_IR,
        ST_DECODE,
        ST_NOOP,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_STORE,
        ST_ADD,
        ST_SUB,
        ST_HALT
    } state_e;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int DADDR_MSB = 11;
    localparam int DADDR_LSB = 4;
    localparam int RA_MSB    = 11;
    localparam int RA_LSB    = 8;
    localparam int RB_MSB    = 7;
    localparam int RB_LSB    = 4;
    localparam int REG_MSB   = 3;
    localparam int REG_LSB   = 0;

endpackage

// File: rtl/control_unit_if.sv
// Bundle of instruction-ROM and datapath control lines driven by control_unit.
interface control_unit_if #(
    parameter int PC_W     = 7,
    parameter int D_ADDR_W = 8
) ();
    logic [15:0]         Instr;
    logic [PC_W-1:0]     PC_addr;
    logic [D_ADDR_W-1:0] D_addr;
    logic                D_wr;
    logic                RF_s;
    logic [3:0]          RF_W_addr;
    logic                RF_W_en;
    logic [3:0]          RF_Ra_addr;
    logic [3:0]          RF_Rb_addr;
    logic [2:0]          ALU_s0;
    logic                Halted;

    modport master (
        input  Instr,
        output PC_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted
    );

    modport slave (
        output Instr,
        input  PC_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted
    );
endinterface

// File: rtl/pc_counter.sv
// Program counter: clears on clr, increments (with natural wrap) on up.
module pc_counter #(
    parameter int PC_W = 7
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            clr,
    input  logic            up,
    output logic [PC_W-1:0] pc
);
    logic [PC_W-1:0] pc_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_reg <= '0;
        end else if (clr) begin
            pc_reg <= '0;
        end else if (up) begin
            pc_reg <= pc_reg + PC_W'(1);
        end
    end

    assign pc = pc_reg;
endmodule

// File: rtl/control_unit.sv
// Processor sequencer: fetch/decode/execute FSM plus instruction register,
// with Moore control outputs decoded from the state and IR.
module control_unit
    import proc_pkg::*;
#(
    parameter int PC_W     = 7,
    parameter int D_ADDR_W = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    control_unit_if.master bus
);
    state_e              state_reg;
    state_e              state_next;
    logic [15:0]         ir_reg;
    logic [3:0]          opcode;
    logic [PC_W-1:0]     pc_value;

    logic [D_ADDR_W-1:0] d_addr;
    logic                d_wr;
    logic                rf_s;
    logic [3:0]          rf_w_addr;
    logic                rf_w_en;
    logic [3:0]          rf_ra_addr;
    logic [3:0]          rf_rb_addr;
    logic [2:0]          alu_s0;
    logic                halted;

    assign opcode = ir_reg[OPC_MSB:OPC_LSB];

    pc_counter #(.PC_W(PC_W)) u_pc (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (state_reg == ST_INIT),
        .up      (state_reg == ST_LOAD_IR),
        .pc      (pc_value)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ir_reg <= '0;
        end else if (state_reg == ST_INIT) begin
            ir_reg <= '0;
        end else if (state_reg == ST_LOAD_IR) begin
            ir_reg <= bus.Instr;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT:    state_next = ST_FETCH;
            ST_FETCH:   state_next = ST_LOAD_IR;
            ST_LOAD_IR: state_next = ST_DECODE;
            ST_DECODE: begin
                // Any opcode outside the defined set halts the machine.
                case (opcode)
                    OP_NOOP:  state_next = ST_NOOP;
                    OP_STORE: state_next = ST_STORE;
                    OP_LOAD:  state_next = ST_LOAD_A;
                    OP_ADD:   state_next = ST_ADD;
                    OP_SUB:   state_next = ST_SUB;
                    default:  state_next = ST_HALT;
                endcase
            end
            ST_LOAD_A:  state_next = ST_LOAD_B;
            ST_NOOP,
            ST_LOAD_B,
            ST_STORE,
            ST_ADD,
            ST_SUB:     state_next = ST_FETCH;
            ST_HALT:    state_next = ST_HALT;
            default:    state_next = ST_INIT;
        endcase
    end

    always_comb begin
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s0     = ALU_PASS;
        halted     = 1'b0;
        case (state_reg)
            ST_LOAD_A, ST_LOAD_B: begin
                d_addr    = D_ADDR_W'(ir_reg[DADDR_MSB:DADDR_LSB]);
                rf_s      = 1'b1;
                rf_w_addr = ir_reg[REG_MSB:REG_LSB];
                rf_w_en   = (state_reg == ST_LOAD_B);
            end
            ST_STORE: begin
                d_addr     = D_ADDR_W'(ir_reg[DADDR_MSB:DADDR_LSB]);
                rf_ra_addr = ir_reg[REG_MSB:REG_LSB];
                d_wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                rf_ra_addr = ir_reg[RA_MSB:RA_LSB];
                rf_rb_addr = ir_reg[RB_MSB:RB_LSB];
                rf_w_addr  = ir_reg[REG_MSB:REG_LSB];
                rf_w_en    = 1'b1;
                alu_s0     = (state_reg == ST_ADD) ? ALU_ADD : ALU_SUB;
            end
            ST_HALT:    halted = 1'b1;
            default:    ;
        endcase
    end

    assign bus.PC_addr    = pc_value;
    assign bus.D_addr     = d_addr;
    assign bus.D_wr       = d_wr;
    assign bus.RF_s       = rf_s;
    assign bus.RF_W_addr  = rf_w_addr;
    assign bus.RF_W_en    = rf_w_en;
    assign bus.RF_Ra_addr = rf_ra_addr;
    assign bus.RF_Rb_addr = rf_rb_addr;
    assign bus.ALU_s0     = alu_s0;
    assign bus.Halted     = halted;
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level model queues the
// expected per-cycle control outputs, a monitor compares them every cycle.
module tb_control_unit;

    typedef struct packed {
        logic [6:0] pc;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] wa;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
        logic       halted;
    } outv_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic mon_en = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [15:0] rom [128];
    outv_t exp_q [$];

    control_unit_if #(.PC_W(7), .D_ADDR_W(8)) bus ();

    control_unit #(.PC_W(7), .D_ADDR_W(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) bus.Instr <= rom[bus.PC_addr];

    function automatic outv_t sample();
        outv_t s;
        s.pc     = bus.PC_addr;
        s.d_addr = bus.D_addr;
        s.d_wr   = bus.D_wr;
        s.rf_s   = bus.RF_s;
        s.wa     = bus.RF_W_addr;
        s.w_en   = bus.RF_W_en;
        s.ra     = bus.RF_Ra_addr;
        s.rb     = bus.RF_Rb_addr;
        s.alu    = bus.ALU_s0;
        s.halted = bus.Halted;
        return s;
    endfunction

    task automatic check(input string name, input outv_t act, input outv_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_cycle: got %h expected nothing", sample());
                end else begin
                    check("cycle", sample(), exp_q.pop_front());
                end
            end
        end
    end

    // Expected outputs for one cycle with only PC_addr nonzero.
    function automatic outv_t idle(input int pc);
        outv_t v = '0;
        v.pc = 7'(pc);
        return v;
    endfunction

    task automatic model_fetch(inout int pc);
        exp_q.push_back(idle(pc));            // FETCH
        exp_q.push_back(idle(pc));            // LOAD_IR
        pc = (pc + 1) % 128;
        exp_q.push_back(idle(pc));            // DECODE
    endtask

    task automatic model_exec(input int pc, input logic [15:0] w, input int tail,
                              output bit halted);
        outv_t v = idle(pc);
        int op = int'(w[15:12]);
        halted = 1'b0;
        case (op)
            0: exp_q.push_back(v);
            1: begin
                v.d_addr = w[11:4]; v.ra = w[3:0]; v.d_wr = 1'b1;
                exp_q.push_back(v);
            end
            2: begin
                v.d_addr = w[11:4]; v.rf_s = 1'b1; v.wa = w[3:0];
                exp_q.push_back(v);
                v.w_en = 1'b1;
                exp_q.push_back(v);
            end
            3, 4: begin
                v.ra = w[11:8]; v.rb = w[7:4]; v.wa = w[3:0]; v.w_en = 1'b1;
                v.alu = (op == 3) ? 3'd1 : 3'd2;
                exp_q.push_back(v);
            end
            default: begin
                v.halted = 1'b1;
                for (int i = 0; i < tail; i++) exp_q.push_back(v);
                halted = 1'b1;
            end
        endcase
    endtask

    task automatic start_and_drain();
        int budget = exp_q.size() + 20;
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        check("init_after_release", sample(), '0);
        mon_en = 1'b1;
        while (budget > 0 && exp_q.size() > 0) begin
            @(posedge Clk);
            #2;
            budget--;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
            exp_q.delete();
        end
        mon_en = 1'b0;
    endtask

    task automatic do_reset(input string name);
        Reset_n = 1'b0;
        #1;
        check(name, sample(), '0);
        repeat (2) @(posedge Clk);
        #1;
        check({name, "_held"}, sample(), '0);
    endtask

    task automatic run_program(input int n_instr, input int tail);
        int pc = 0;
        bit h;
        for (int i = 0; i < n_instr; i++) begin
            logic [15:0] w = rom[pc];
            $display("instr %0d pc=%0d word=%h", i, pc, w);
            model_fetch(pc);
            model_exec(pc, w, tail, h);
            if (h) break;
        end
        start_and_drain();
    endtask

    task automatic fill_random(input bit with_halt);
        for (int a = 0; a < 128; a++) begin
            logic [3:0] op = 4'($urandom_range(0, 4));
            rom[a] = {op, 12'($urandom)};
        end
        if (with_halt) rom[$urandom_range(20, 100)] = {4'($urandom_range(5, 15)), 12'($urandom)};
    endtask

    initial begin
        outv_t v;
        for (int a = 0; a < 128; a++) rom[a] = 16'h0000;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_state", sample(), '0);

        // Directed: LOAD, ADD, SUB, STORE, NOOP, HALT
        rom[0] = 16'h2A53; rom[1] = 16'h3123; rom[2] = 16'h4456;
        rom[3] = 16'h1FF7; rom[4] = 16'h0000; rom[5] = 16'h5000;
        run_program(10, 24);
        do_reset("reset_after_halt");

        // Illegal opcode behaves as HALT
        rom[0] = 16'h0000; rom[1] = 16'hF000;
        run_program(10, 24);
        do_reset("reset_after_illegal");

        // Reset asserted in the middle of ADD
        rom[0] = 16'h3123;
        begin
            int pc = 0;
            $display("instr mid_add pc=0 word=%h", rom[0]);
            model_fetch(pc);
        end
        start_and_drain();
        @(posedge Clk);
        #1;
        v = idle(1);
        v.ra = 4'd1; v.rb = 4'd2; v.wa = 4'd3; v.w_en = 1'b1; v.alu = 3'd1;
        check("add_cycle", sample(), v);
        do_reset("reset_mid_add");

        // Random streams long enough to wrap the PC past 127
        for (int r = 0; r < 4; r++) begin
            fill_random(r == 3);
            run_program(140 + int'($urandom_range(0, 20)), 22);
            #($urandom_range(1, 8));
            do_reset("reset_random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencing block of the programmable processor. It holds the program counter and instruction register, fetches 16-bit instructions from the synchronous instruction ROM, and drives every control line of the datapath: data memory, register file, ALU select, and the `RF_s` select of the register-file write-data mux. It feeds the write-data mux directly. Its outputs choose whether the register file is written from data memory (`RF_s`=1) or from the ALU (`RF_s`=0).

## Interface
- `PC_W`, 7: program counter / ROM address width.
- `D_ADDR_W`, 8: data memory address width.
- `Clk`  in  1: single clock; all state updates on its rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `Instr`  in  16: ROM read data; valid one cycle after `PC_addr` is presented.
- `PC_addr`  out  PC_W: instruction ROM address, equal to the PC register.
- `D_addr`  out  D_ADDR_W: data memory address.
- `D_wr`  out  1: data memory write enable.
- `RF_s`  out  1: write-data mux select; 1 = memory data, 0 = ALU result.
- `RF_W_addr`  out  4: register file write address.
- `RF_W_en`  out  1: register file write enable.
- `RF_Ra_addr`, `RF_Rb_addr`  out  4 each: register file read addresses.
- `ALU_s0`  out  3: ALU function select. 0 = pass/zero, 1 = add, 2 = subtract.
- `Halted`  out  1: high while in HALT.

## Operation
- **Opcode field:** `IR[15:12]`.
  - 0 NOOP
  - 1 STORE: `D_addr`=`IR[11:4]`, source reg `IR[3:0]`
  - 2 LOAD: `D_addr`=`IR[11:4]`, dest reg `IR[3:0]`
  - 3 ADD: Ra=`IR[11:8]`, Rb=`IR[7:4]`, Wa=`IR[3:0]`
  - 4 SUB: same fields as ADD
  - 5 HALT
  - 6–15 illegal, treated as HALT.
- **States:** INIT, FETCH, LOAD_IR, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
- **INIT:** clears PC and IR; next FETCH.
- **FETCH:** `PC_addr` is presented; next LOAD_IR.
- **LOAD_IR:** IR <= `Instr`; PC <= PC+1, wrapping from 2^PC_W−1 to 0; next DECODE.
- **DECODE:** branches on opcode; no datapath strobes are asserted.
- **NOOP:** next FETCH.
- **LOAD_A:** `D_addr`=`IR[11:4]`, `RF_s`=1, `RF_W_addr`=`IR[3:0]`, `RF_W_en`=0. Covers the memory read latency. Next LOAD_B.
- **LOAD_B:** same outputs as LOAD_A with `RF_W_en`=1; next FETCH.
- **STORE:** `D_addr`=`IR[11:4]`, `RF_Ra_addr`=`IR[3:0]`, `D_wr`=1; next FETCH.
- **ADD / SUB:** Ra/Rb/Wa from IR, `RF_s`=0, `RF_W_en`=1, `ALU_s0`=1 for ADD or 2 for SUB; next FETCH.
- **HALT:** `Halted`=1, PC frozen, all strobes 0. Left only by reset.
- **Output rules:**
  - Outputs are Moore, decoded from the state register and IR. Any output not listed for a state is 0.
  - `D_wr` and `RF_W_en` are never high in the same cycle.
  - `RF_W_en` is never high in FETCH, LOAD_IR or DECODE.

## Timing
- **Reset:** `Reset_n` low forces, immediately and asynchronously:
  - state INIT, PC=0, IR=0
  - all outputs 0, including `PC_addr`=0 and `Halted`=0.
- **Reset release:** the first rising edge with `Reset_n` high moves INIT to FETCH.
- **Reset mid-instruction:** aborts any instruction in progress. No partial write may occur after the assertion edge.
- **Cycles per instruction, counted from FETCH:**
  - NOOP, STORE, ADD, SUB: 4
  - LOAD: 5
  - HALT: enters the HALT state on the 4th cycle.
- **PC:** updates only in LOAD_IR. `PC_addr` therefore holds steady through the execute states.
- **Memory write:** `D_wr` lasts exactly one cycle per STORE.
- **Register-file write:** `RF_W_en` lasts exactly one cycle per LOAD, ADD or SUB.

## Structure
- **Shared package `proc_pkg`:**
  - opcode enum
  - state enum
  - ALU select constants (ALU_PASS=0, ALU_ADD=1, ALU_SUB=2)
  - instruction field slice positions
- **Sub-module `pc_counter`:**
  - PC_W-bit register with async active-low reset, `clr` and `up` inputs.
  - Controlled by the FSM: `clr` in INIT, `up` in LOAD_IR.
- **Top level:** IR register and FSM stay in `control_unit`.

## Test plan
- **Reset:** hold `Reset_n` low mid-ADD.
  - All outputs drop to 0 immediately and `PC_addr`=0.
  - After release, the FSM steps INIT then FETCH.
- **LOAD:** ROM word 16'h2A53.
  - In LOAD_A and LOAD_B: `D_addr`=8'hA5, `RF_s`=1, `RF_W_addr`=3.
  - `RF_W_en`=1 in LOAD_B only.
  - 5 cycles total; PC advances by 1.
- **ADD:** ROM word 16'h3123.
  - In the single ADD cycle: `RF_Ra_addr`=1, `RF_Rb_addr`=2, `RF_W_addr`=3, `ALU_s0`=1, `RF_s`=0, `RF_W_en`=1.
- **SUB:** ROM word 16'h4456 gives the same shape as ADD with `ALU_s0`=2.
- **STORE:** ROM word 16'h1FF7.
  - `D_addr`=8'hFF, `RF_Ra_addr`=7, `D_wr`=1 for exactly one cycle, `RF_W_en`=0.
- **HALT, illegal opcode, PC wrap:**
  - ROM word 16'h5000 or 16'hF000: `Halted`=1 and `PC_addr` frozen for 20+ cycles, until reset.
  - A NOOP stream starting at PC=127 wraps `PC_addr` to 0.
